// File: rtl/arbitro_memoria_onchip.sv
// arbitro_memoria_onchip
// Round-robin arbiter that shares one on-chip memory port (Qsys style
// read/write/address/writedata + op_complete) among NUM_SOLICITANTES requesters.
// One request is latched at a time; the winner gets read data and a one-cycle
// listo pulse when the memory reports completion.
// Optional build macro ARBITRO_PRIORIDAD_FIJA_EN: fixed priority (lowest index
// wins, no rotating pointer). Ports and timing are identical in both builds.
module arbitro_memoria_onchip #(
  parameter int NUM_SOLICITANTES     = 4,
  parameter int BITS_MEMORY_DATA     = 32,
  parameter int BITS_ADDR_MEM_ONCHIP = 14
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic [NUM_SOLICITANTES-1:0]                      solicitud,
  input  logic [NUM_SOLICITANTES-1:0]                      escritura,
  input  logic [NUM_SOLICITANTES*BITS_ADDR_MEM_ONCHIP-1:0] direccion,
  input  logic [NUM_SOLICITANTES*BITS_MEMORY_DATA-1:0]     dato_escritura,
  output logic [NUM_SOLICITANTES-1:0]                      listo,
  output logic [BITS_MEMORY_DATA-1:0]                      dato_lectura,
  output logic [NUM_SOLICITANTES-1:0]                      concesion,
  input  logic                                             op_complete_mem,
  input  logic [BITS_MEMORY_DATA-1:0]                      data_mem,
  output logic                                             read_mem,
  output logic                                             write_mem,
  output logic [BITS_ADDR_MEM_ONCHIP-1:0]                  address_mem,
  output logic [BITS_MEMORY_DATA-1:0]                      write_data_mem
);

  localparam int PTR_W = $clog2(NUM_SOLICITANTES);

  localparam logic [1:0] REPOSO = 2'd0;
  localparam logic [1:0] ACCESO = 2'd1;
  localparam logic [1:0] FIN    = 2'd2;

  localparam logic [NUM_SOLICITANTES-1:0] UNO_HOT = NUM_SOLICITANTES'(1);

  logic [1:0]                      r_estado;
  logic [NUM_SOLICITANTES-1:0]     r_concesion;
  logic [NUM_SOLICITANTES-1:0]     r_listo;
  logic [BITS_MEMORY_DATA-1:0]     r_dato_lectura;
  logic                            r_read;
  logic                            r_write;
  logic [BITS_ADDR_MEM_ONCHIP-1:0] r_direccion;
  logic [BITS_MEMORY_DATA-1:0]     r_dato_escritura;

  logic                            w_hay_solicitud;
  logic [PTR_W-1:0]                w_ganador;
  logic                            w_escritura_sel;
  logic [BITS_ADDR_MEM_ONCHIP-1:0] w_direccion_sel;
  logic [BITS_MEMORY_DATA-1:0]     w_dato_sel;

`ifdef ARBITRO_PRIORIDAD_FIJA_EN

  // Fixed priority: downward scan so the lowest set index is the last writer.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no
    // path leaves it unassigned and no latch is inferred.
    w_hay_solicitud = 1'b0;
    w_ganador       = '0;
    for (int i = NUM_SOLICITANTES - 1; i >= 0; i--) begin
      if (solicitud[i]) begin
        w_hay_solicitud = 1'b1;
        w_ganador       = PTR_W'(i);
      end
    end
  end

`else

  logic [PTR_W-1:0] r_puntero;
  logic [PTR_W-1:0] r_indice;
  logic [PTR_W-1:0] w_pos;

  // Round robin: scan offsets downward from pointer+N-1 to pointer+0 so the
  // first set bit at or after the pointer is the one that sticks.
  always_comb begin
    w_hay_solicitud = 1'b0;
    w_ganador       = '0;
    w_pos           = '0;
    for (int i = NUM_SOLICITANTES - 1; i >= 0; i--) begin
      w_pos = PTR_W'((int'(r_puntero) + i) % NUM_SOLICITANTES);
      if (solicitud[w_pos]) begin
        w_hay_solicitud = 1'b1;
        w_ganador       = w_pos;
      end
    end
  end

  // Remember the owner and advance the pointer past it once its access is done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_indice  <= '0;
      r_puntero <= '0;
    end else begin
      if (r_estado == REPOSO && w_hay_solicitud) begin
        r_indice <= w_ganador;
      end
      if (r_estado == ACCESO && op_complete_mem) begin
        r_puntero <= (r_indice == PTR_W'(NUM_SOLICITANTES - 1)) ? '0 : r_indice + 1'b1;
      end
    end
  end

`endif

  // Select the winner's operation, address and write-data slices.
  always_comb begin
    w_escritura_sel = 1'b0;
    w_direccion_sel = '0;
    w_dato_sel      = '0;
    for (int i = 0; i < NUM_SOLICITANTES; i++) begin
      if (w_ganador == PTR_W'(i)) begin
        w_escritura_sel = escritura[i];
        w_direccion_sel = direccion[i*BITS_ADDR_MEM_ONCHIP +: BITS_ADDR_MEM_ONCHIP];
        w_dato_sel      = dato_escritura[i*BITS_MEMORY_DATA +: BITS_MEMORY_DATA];
      end
    end
  end

  // Access sequencer: REPOSO grants, ACCESO holds the command, FIN pulses listo.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of statement order.
    if (reset) begin
      r_estado         <= REPOSO;
      r_concesion      <= '0;
      r_listo          <= '0;
      r_dato_lectura   <= '0;
      r_read           <= 1'b0;
      r_write          <= 1'b0;
      r_direccion      <= '0;
      r_dato_escritura <= '0;
    end else begin
      case (r_estado)
        REPOSO: begin
          if (w_hay_solicitud) begin
            r_concesion      <= UNO_HOT << w_ganador;
            r_read           <= ~w_escritura_sel;
            r_write          <= w_escritura_sel;
            r_direccion      <= w_direccion_sel;
            r_dato_escritura <= w_escritura_sel ? w_dato_sel : '0;
            r_estado         <= ACCESO;
          end
        end
        ACCESO: begin
          if (op_complete_mem) begin
            if (r_read) begin
              r_dato_lectura <= data_mem;
            end
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_listo  <= r_concesion;
            r_estado <= FIN;
          end
        end
        FIN: begin
          r_listo     <= '0;
          r_concesion <= '0;
          r_estado    <= REPOSO;
        end
        default: begin
          r_estado <= REPOSO;
        end
      endcase
    end
  end

  assign listo          = r_listo;
  assign dato_lectura   = r_dato_lectura;
  assign concesion      = r_concesion;
  assign read_mem       = r_read;
  assign write_mem      = r_write;
  assign address_mem    = r_direccion;
  assign write_data_mem = r_dato_escritura;

endmodule

// File: tb/tb_arbitro_memoria_onchip.sv
// Testbench for arbitro_memoria_onchip: directed scenarios plus randomized
// requester traffic, checked by a scoreboard fed from a behavioural model.
// Honours ARBITRO_PRIORIDAD_FIJA_EN for the arbitration rule.
module tb_arbitro_memoria_onchip;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 14;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    solicitud, escritura, listo, concesion;
  logic [N*AW-1:0] direccion;
  logic [N*DW-1:0] dato_escritura;
  logic [DW-1:0]   dato_lectura, data_mem, write_data_mem;
  logic            op_complete_mem, read_mem, write_mem;
  logic [AW-1:0]   address_mem;

  arbitro_memoria_onchip #(
    .NUM_SOLICITANTES(N), .BITS_MEMORY_DATA(DW), .BITS_ADDR_MEM_ONCHIP(AW)
  ) dut (
    .clk(clk), .reset(reset), .solicitud(solicitud), .escritura(escritura),
    .direccion(direccion), .dato_escritura(dato_escritura), .listo(listo),
    .dato_lectura(dato_lectura), .concesion(concesion),
    .op_complete_mem(op_complete_mem), .data_mem(data_mem),
    .read_mem(read_mem), .write_mem(write_mem), .address_mem(address_mem),
    .write_data_mem(write_data_mem)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  function automatic logic [DW-1:0] mem_default(input logic [AW-1:0] a);
    return 32'hA5A5_0000 ^ {18'h0, a};
  endfunction

  // ---------------- requester agents ----------------
  int            pend [N];
  bit            use_dir [N];
  logic          dir_we [N];
  logic [AW-1:0] dir_addr [N];
  logic [DW-1:0] dir_data [N];
  bit            rand_en = 1'b0;

  initial begin
    solicitud = '0; escritura = '0; direccion = '0; dato_escritura = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (solicitud[k] && listo[k] && pend[k] > 0) pend[k]--;
        if (pend[k] > 0) begin
          if (!solicitud[k] || listo[k]) begin
            if (use_dir[k]) begin
              escritura[k]                = dir_we[k];
              direccion[k*AW +: AW]       = dir_addr[k];
              dato_escritura[k*DW +: DW]  = dir_data[k];
            end else begin
              escritura[k]                = 1'($urandom_range(0, 1));
              direccion[k*AW +: AW]       = ($urandom_range(0, 3) == 0) ? AW'($urandom)
                                                                        : AW'($urandom_range(0, 15));
              dato_escritura[k*DW +: DW]  = $urandom;
            end
          end
          solicitud[k] = 1'b1;
        end else begin
          solicitud[k] = 1'b0;
        end
        if (rand_en && pend[k] == 0 && $urandom_range(0, 5) == 0) pend[k] = $urandom_range(1, 3);
      end
    end
  end

  // ---------------- memory responder ----------------
  logic [DW-1:0] resp_mem [int];
  int            fixed_lat  = -1;
  bit            spur_en    = 1'b0;
  bit            inject_opc = 1'b0;

  initial begin
    int cnt;
    int lat;
    cnt = 0; lat = 1;
    op_complete_mem = 1'b0; data_mem = '0;
    forever begin
      @(negedge clk);
      op_complete_mem = 1'b0;
      data_mem        = $urandom;
      if (read_mem || write_mem) begin
        if (cnt >= lat) begin
          op_complete_mem = 1'b1;
          if (write_mem) resp_mem[int'(address_mem)] = write_data_mem;
          else data_mem = resp_mem.exists(int'(address_mem)) ? resp_mem[int'(address_mem)]
                                                              : mem_default(address_mem);
          cnt = 0;
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
        lat = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
        if (inject_opc || (spur_en && $urandom_range(0, 3) == 0)) op_complete_mem = 1'b1;
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    int            req;
    bit            we;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb_q [$];
  logic [DW-1:0] ref_mem [int];
  int            model_ptr = 0;
  logic [DW-1:0] last_read = '0;
  int            grant_log [$];
  longint        grant_cyc [$];
  longint        cyc = 0;

  logic [N-1:0]    sol_q, we_q;
  logic [N*AW-1:0] dir_q;
  logic [N*DW-1:0] dat_q;

  // Requests as the arbiter sees them at each rising edge.
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    sol_q <= solicitud;
    we_q  <= escritura;
    dir_q <= direccion;
    dat_q <= dato_escritura;
  end

  function automatic int pick_winner(input logic [N-1:0] s);
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
    for (int i = 0; i < N; i++) if (s[i]) return i;
`else
    for (int i = 0; i < N; i++) begin
      int k = (model_ptr + i) % N;
      if (s[k]) return k;
    end
`endif
    return -1;
  endfunction

  // Grant monitor: on each new memory command, predict winner and payload.
  initial begin
    bit            prev_cmd;
    logic [AW-1:0] cur_a;
    prev_cmd = 1'b0; cur_a = '0;
    forever begin
      @(negedge clk);
      if ((read_mem || write_mem) && !prev_cmd) begin
        int            w;
        exp_t          e;
        logic [N-1:0]  oh;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit            we;
        w = pick_winner(sol_q);
        check("grant_has_request", 1'(w >= 0), 1'b1);
        if (w >= 0) begin
          a = dir_q[w*AW +: AW]; d = dat_q[w*DW +: DW]; we = we_q[w];
          oh = '0; oh[w] = 1'b1;
          check("concesion", concesion, oh);
          check("read_mem", read_mem, !we);
          check("write_mem", write_mem, we);
          check("address_mem", address_mem, a);
          check("write_data_mem", write_data_mem, we ? d : '0);
          e.req = w; e.we = we;
          if (we) begin
            ref_mem[int'(a)] = d;
            e.data = '0;
          end else begin
            e.data = ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : mem_default(a);
          end
          sb_q.push_back(e);
          grant_log.push_back(w);
          grant_cyc.push_back(cyc);
          cur_a = a;
`ifndef ARBITRO_PRIORIDAD_FIJA_EN
          model_ptr = (w + 1) % N;
`endif
        end
      end else if (read_mem || write_mem) begin
        check("address_stable", address_mem, cur_a);
      end
      check("cmd_exclusive", read_mem & write_mem, 1'b0);
      prev_cmd = read_mem || write_mem;
    end
  end

  // Completion monitor: every listo pulse must match the oldest grant.
  initial begin
    forever begin
      @(negedge clk);
      if (listo !== '0) begin
        if (sb_q.size() == 0) begin
          check("listo_unexpected", listo, '0);
        end else begin
          exp_t          e;
          logic [N-1:0]  oh;
          logic [DW-1:0] exp_d;
          e = sb_q.pop_front();
          oh = '0; oh[e.req] = 1'b1;
          exp_d = e.we ? last_read : e.data;
          check("listo", listo, oh);
          check("concesion_fin", concesion, oh);
          check("dato_lectura", dato_lectura, exp_d);
          last_read = exp_d;
        end
      end else begin
        check("dato_lectura_hold", dato_lectura, last_read);
      end
    end
  end

  // ---------------- directed helpers ----------------
  int            t_rise, t_cmd, t_listo;
  logic [N-1:0]  t_conc, t_listo_v;
  logic [AW-1:0] t_addr;
  logic [DW-1:0] t_wdata, t_dl;
  bit            t_rd, t_wr;

  task automatic do_access(input int k, input bit we, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, input int lat);
    fixed_lat = lat;
    use_dir[k] = 1'b1; dir_we[k] = we; dir_addr[k] = a; dir_data[k] = d;
    pend[k] = 1;
    t_rise = -1; t_listo = -1; t_cmd = 0; t_rd = 1'b0; t_wr = 1'b0;
    for (int s = 1; s <= 60 && t_listo < 0; s++) begin
      step();
      if (read_mem || write_mem) begin
        if (t_rise < 0) t_rise = s;
        t_cmd++;
        t_conc = concesion; t_addr = address_mem; t_wdata = write_data_mem;
        t_rd |= read_mem; t_wr |= write_mem;
      end
      if (listo != '0) begin
        t_listo = s; t_listo_v = listo; t_dl = dato_lectura;
      end
    end
    use_dir[k] = 1'b0;
    check("access_completes", 1'(t_listo > 0), 1'b1);
  endtask

  task automatic wait_idle(input int budget);
    bit idle;
    idle = 1'b0;
    for (int s = 0; s < budget && !idle; s++) begin
      step();
      idle = (solicitud == '0) && !read_mem && !write_mem && (listo == '0) && (concesion == '0);
      for (int k = 0; k < N; k++) if (pend[k] != 0) idle = 1'b0;
    end
    check("idle_reached", idle, 1'b1);
    check("scoreboard_empty", sb_q.size(), 0);
  endtask

  task automatic model_reset();
    sb_q.delete();
    grant_log.delete();
    grant_cyc.delete();
    model_ptr = 0;
    last_read = '0;
    for (int k = 0; k < N; k++) begin
      pend[k] = 0;
      use_dir[k] = 1'b0;
    end
  endtask

  // Watchdog: the run must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int got;
    reset = 1'b1;
    repeat (3) step();
    check("rst_read_mem", read_mem, 1'b0);
    check("rst_write_mem", write_mem, 1'b0);
    check("rst_listo", listo, '0);
    check("rst_concesion", concesion, '0);
    check("rst_dato_lectura", dato_lectura, '0);
    check("rst_address_mem", address_mem, '0);
    check("rst_write_data_mem", write_data_mem, '0);

    // Fairness: every requester holds solicitud from reset.
    fixed_lat = 0;
    for (int k = 0; k < N; k++) pend[k] = 100;
    step();
    reset = 1'b0;
    for (int s = 0; s < 100 && grant_log.size() < 6; s++) step();
    check("fair_grant_count", 1'(grant_log.size() >= 6), 1'b1);
    if (grant_log.size() >= 6) begin
`ifdef ARBITRO_PRIORIDAD_FIJA_EN
      for (int i = 0; i < 3; i++) check($sformatf("fair_order_%0d", i), grant_log[i], 0);
`else
      for (int i = 0; i < 6; i++) check($sformatf("fair_order_%0d", i), grant_log[i], i % N);
`endif
      for (int i = 1; i < 6; i++)
        check($sformatf("fair_gap_%0d", i), grant_cyc[i] - grant_cyc[i-1], 3);
    end
    for (int k = 0; k < N; k++) pend[k] = 0;
    wait_idle(100);

    // Single read: requester 2, address 0x0010, memory answers after 3 cycles.
    ref_mem[16'h0010] = 32'hDEAD_BEEF;
    resp_mem[16'h0010] = 32'hDEAD_BEEF;
    do_access(2, 1'b0, 14'h0010, 32'h0, 2);
    check("rd_rise_latency", t_rise, 2);
    check("rd_cycles", t_cmd, 3);
    check("rd_concesion", t_conc, 4'b0100);
    check("rd_address", t_addr, 14'h0010);
    check("rd_no_write", t_wr, 1'b0);
    check("rd_listo_latency", t_listo, t_rise + t_cmd);
    check("rd_listo", t_listo_v, 4'b0100);
    check("rd_data", t_dl, 32'hDEAD_BEEF);
    wait_idle(20);

    // Write: requester 1 writes 0x12345678 to 0x3FFF, then requester 0 reads it.
    do_access(1, 1'b1, 14'h3FFF, 32'h1234_5678, 1);
    check("wr_seen", t_wr, 1'b1);
    check("wr_no_read", t_rd, 1'b0);
    check("wr_data", t_wdata, 32'h1234_5678);
    check("wr_address", t_addr, 14'h3FFF);
    check("wr_listo", t_listo_v, 4'b0010);
    check("wr_dato_lectura_kept", t_dl, 32'hDEAD_BEEF);
    wait_idle(20);
    do_access(0, 1'b0, 14'h3FFF, 32'h0, 0);
    check("rdback_data", t_dl, 32'h1234_5678);
    wait_idle(20);

    // Wrap: 3 served, then 0 and 3 pend together.
    grant_log.delete();
    fixed_lat = 1;
    pend[3] = 2;
    got = 0;
    for (int s = 0; s < 30 && got == 0; s++) begin
      step();
      if (listo[3]) got = 1;
    end
    check("wrap_first_listo", got, 1);
    pend[0] = 1;
    wait_idle(60);
    check("wrap_grants", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      check("wrap_g0", grant_log[0], 3);
      check("wrap_g1", grant_log[1], 0);
      check("wrap_g2", grant_log[2], 3);
    end

    // Reset in the middle of an access.
    fixed_lat = 20;
    use_dir[2] = 1'b1; dir_we[2] = 1'b0; dir_addr[2] = 14'h0123; dir_data[2] = '0;
    pend[2] = 1;
    got = 0;
    for (int s = 0; s < 10 && got == 0; s++) begin
      step();
      if (read_mem) got = 1;
    end
    check("rstmid_read_active", got, 1);
    #1 reset = 1'b1;
    #1;
    check("rstmid_read_mem", read_mem, 1'b0);
    check("rstmid_write_mem", write_mem, 1'b0);
    check("rstmid_concesion", concesion, '0);
    check("rstmid_listo", listo, '0);
    check("rstmid_dato_lectura", dato_lectura, '0);
    model_reset();
    step(); step();
    reset = 1'b0;
    step();
    do_access(1, 1'b0, 14'h0020, 32'h0, 1);
    check("post_rst_listo", t_listo_v, 4'b0010);
    check("post_rst_grants", grant_log.size(), 1);
    if (grant_log.size() == 1) check("post_rst_winner", grant_log[0], 1);
    wait_idle(20);

    // Spurious op_complete_mem while idle.
    inject_opc = 1'b1;
    step();
    inject_opc = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      check("spur_listo", listo, '0);
      check("spur_cmd", {read_mem, write_mem}, 2'b00);
      check("spur_concesion", concesion, '0);
      check("spur_dato_lectura", dato_lectura, last_read);
    end
    do_access(2, 1'b0, 14'h0010, 32'h0, 0);
    check("spur_next_rise", t_rise, 2);
    check("spur_next_data", t_dl, 32'hDEAD_BEEF);
    wait_idle(20);

    // Randomized traffic with random latency and stray op_complete pulses.
    fixed_lat = -1;
    spur_en = 1'b1;
    rand_en = 1'b1;
    repeat (3000) step();
    rand_en = 1'b0;
    wait_idle(600);
    spur_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
